// File: rtl/fp_add_sequencer_if.sv
// fp_add_sequencer_if: operand and result valid/ready handshakes for fp_add_sequencer
interface fp_add_sequencer_if #(parameter int EXP_N = 8, parameter int FRAC_N = 23);
   logic                  in_valid, in_ready, out_valid, out_ready;
   logic [EXP_N+FRAC_N:0] op_a, op_b, result;
   modport master (output in_valid, op_a, op_b, out_ready, input in_ready, out_valid, result);
   modport slave (input in_valid, op_a, op_b, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 adder controller driving an external Normalizer.
// Define FP_ADD_SPECIALS_EN to resolve Inf/NaN operands in ALIGN and skip straight to DONE.
module fp_add_sequencer #(
   parameter int EXP_N   = 8,
   parameter int FRAC_N  = 23,
   parameter int SHIFT_W = $clog2(FRAC_N + 9)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fp_add_sequencer_if.slave    bus,
   output logic                 busy,
   output logic [FRAC_N+1:0]    norm_mantissa,
   output logic [EXP_N-1:0]     norm_exp,
   output logic                 norm_shift_right,
   input  logic [FRAC_N+1:0]    normed_mantissa,
   input  logic [EXP_N-1:0]     normed_exp,
   input  logic [SHIFT_W-1:0]   norm_index,
   input  logic                 norm_valid
);
   localparam int M = FRAC_N + 2;
   localparam int W = 1 + EXP_N + FRAC_N;
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
   state_t state, state_nx;
   logic [W-1:0] a, b, res, norm_res;
   logic [EXP_N-1:0] ea, eb, d, exp_l, shift;
   logic [M-1:0] ma, mb, ms_sh, man_l, man_s;
   logic swap, sign_l, sub, unused_bits;
   assign ea = a[W-2:FRAC_N];
   assign eb = b[W-2:FRAC_N];
   assign ma = {1'b0, |ea, a[FRAC_N-1:0]};
   assign mb = {1'b0, |eb, b[FRAC_N-1:0]};
   assign swap = b[W-2:0] > a[W-2:0];
   assign d = swap ? eb - ea : ea - eb;
   assign ms_sh = d >= EXP_N'(M) ? '0 : (swap ? ma : mb) >> d;
   assign shift = EXP_N'(FRAC_N) - EXP_N'(norm_index);
   assign norm_shift_right = norm_mantissa[M-1];
   assign norm_res = !norm_valid ? '0
      : norm_shift_right && norm_exp == {{(EXP_N-1){1'b1}}, 1'b0} ? {sign_l, {EXP_N{1'b1}}, {FRAC_N{1'b0}}}
      : !norm_shift_right && shift >= norm_exp ? {sign_l, {(EXP_N+FRAC_N){1'b0}}}
      : {sign_l, normed_exp, normed_mantissa[FRAC_N-1:0]};
   assign unused_bits = &{1'b0, normed_mantissa[M-1:FRAC_N]};
   assign bus.in_ready = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.result = res;
   assign busy = state != IDLE;
`ifdef FP_ADD_SPECIALS_EN
   logic inf_a, inf_b, nan_a, nan_b, special;
   logic [W-1:0] special_res;
   assign inf_a = &ea && ~|a[FRAC_N-1:0];
   assign inf_b = &eb && ~|b[FRAC_N-1:0];
   assign nan_a = &ea && |a[FRAC_N-1:0];
   assign nan_b = &eb && |b[FRAC_N-1:0];
   assign special = &ea || &eb;
   // Opposite infinities have no defined sum, so they collapse to the canonical quiet NaN
   assign special_res = nan_a || nan_b || (inf_a && inf_b && a[W-1] != b[W-1])
      ? {1'b0, {EXP_N{1'b1}}, 1'b1, {(FRAC_N-1){1'b0}}} : inf_a ? a : b;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.in_valid ? ALIGN : IDLE;
`ifdef FP_ADD_SPECIALS_EN
         ALIGN:   state_nx = special ? DONE : ADD;
`else
         ALIGN:   state_nx = ADD;
`endif
         ADD:     state_nx = NORM;
         NORM:    state_nx = DONE;
         DONE:    state_nx = bus.out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a <= '0;
         b <= '0;
         res <= '0;
         sign_l <= 1'b0;
         sub <= 1'b0;
         exp_l <= '0;
         man_l <= '0;
         man_s <= '0;
         norm_mantissa <= '0;
         norm_exp <= '0;
      end else begin
         if (state == IDLE && bus.in_valid) begin
            a <= bus.op_a;
            b <= bus.op_b;
         end
         if (state == ALIGN) begin
            sign_l <= swap ? b[W-1] : a[W-1];
            sub <= a[W-1] ^ b[W-1];
            exp_l <= swap ? eb : ea;
            man_l <= swap ? mb : ma;
            man_s <= ms_sh;
`ifdef FP_ADD_SPECIALS_EN
            if (special) res <= special_res;
`endif
         end
         if (state == ADD) begin
            norm_mantissa <= sub ? man_l - man_s : man_l + man_s;
            norm_exp <= exp_l;
         end
         if (state == NORM) res <= norm_res;
      end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed vectors for fp_add_sequencer, with a behavioural Normalizer
module tb_fp_add_sequencer;
   logic clk = 1'b0, rst_n = 1'b0;
   logic busy, norm_shift_right, norm_valid, sr_seen;
   logic [24:0] norm_mantissa, normed_mantissa, mant_seen;
   logic [7:0] norm_exp, normed_exp, exp_seen;
   logic [4:0] norm_index;
   int checks = 0, errors = 0;
   fp_add_sequencer_if #(.EXP_N(8), .FRAC_N(23)) ifc ();
   fp_add_sequencer #(.EXP_N(8), .FRAC_N(23), .SHIFT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc), .busy(busy),
      .norm_mantissa(norm_mantissa), .norm_exp(norm_exp), .norm_shift_right(norm_shift_right),
      .normed_mantissa(normed_mantissa), .normed_exp(normed_exp),
      .norm_index(norm_index), .norm_valid(norm_valid));
   always #5 clk = ~clk;
   // Leading-one normalizer: moves the top one to bit 23 and adjusts the exponent
   always_comb begin
      norm_index = 5'd0;
      norm_valid = 1'b0;
      for (int i = 0; i < 25; i++)
         if (norm_mantissa[i]) begin
            norm_index = 5'(i);
            norm_valid = 1'b1;
         end
      normed_mantissa = norm_index == 5'd24 ? norm_mantissa >> 1 : norm_mantissa << (5'd23 - norm_index);
      normed_exp = norm_index == 5'd24 ? 8'(norm_exp + 8'd1) : 8'(norm_exp - 8'(5'd23 - norm_index));
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, want);
      end
   endtask
   task automatic start_op(input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      while (!ifc.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_idle", 32'(ifc.in_ready), 32'd1);
      ifc.op_a = x;
      ifc.op_b = y;
      ifc.in_valid = 1'b1;
      @(negedge clk);
      ifc.in_valid = 1'b0;
   endtask
   // Called on the first falling edge after the accepting edge (cycle 1 = ALIGN)
   task automatic finish_op(input logic [31:0] want, input int lat, input string tag, input int hold);
      int n = 1;
      while (!ifc.out_valid && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 3) begin
            sr_seen = norm_shift_right;
            mant_seen = norm_mantissa;
            exp_seen = norm_exp;
         end
      end
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_result"}, ifc.result, want);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 32'(ifc.out_valid), 32'd1);
         chk({tag, "_hold_result"}, ifc.result, want);
         chk({tag, "_hold_in_ready"}, 32'(ifc.in_ready), 32'd0);
      end
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(ifc.out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask
   initial begin
      ifc.in_valid = 1'b0;
      ifc.out_ready = 1'b0;
      ifc.op_a = '0;
      ifc.op_b = '0;
      #12;
      chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", ifc.result, 32'd0);
      chk("rst_norm", {norm_exp, norm_mantissa[23:0]}, 32'd0);
      chk("rst_shift_right", 32'(norm_shift_right), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_op(32'h3F800000, 32'h3F800000);
      finish_op(32'h40000000, 4, "one_plus_one", 0);
      chk("one_plus_one_carry", 32'(sr_seen), 32'd1);
      chk("one_plus_one_mant", 32'(mant_seen), 32'h01000000);
      chk("one_plus_one_exp", 32'(exp_seen), 32'h7F);
      start_op(32'h3F800000, 32'hBF800000);
      finish_op(32'h00000000, 4, "x_minus_x", 0);
      start_op(32'h40400000, 32'hBF800000);
      finish_op(32'h40000000, 4, "three_minus_one", 0);
      start_op(32'h3F800000, 32'h33800000);
      finish_op(32'h3F800000, 4, "d24_truncate", 0);
      start_op(32'h7F7FFFFF, 32'h7F7FFFFF);
      finish_op(32'h7F800000, 4, "overflow_inf", 0);
      start_op(32'h00000000, 32'h40A00000);
      finish_op(32'h40A00000, 4, "zero_pass", 0);
      start_op(32'h00000000, 32'h80000000);
      finish_op(32'h00000000, 4, "pz_plus_nz", 0);
      start_op(32'h00C00000, 32'h80800000);
      finish_op(32'h00000000, 4, "underflow_flush", 0);
      start_op(32'h40000000, 32'h3F800000);
      ifc.op_a = 32'h3F800000;
      ifc.op_b = 32'h3F800000;
      ifc.in_valid = 1'b1;
      finish_op(32'h40400000, 4, "stall", 10);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      chk("accept_after_idle", 32'(busy), 32'd1);
      finish_op(32'h40000000, 4, "after_stall", 0);
      start_op(32'h40000000, 32'h40000000);
      @(negedge clk);
      chk("busy_in_add", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("abort_in_ready", 32'(ifc.in_ready), 32'd1);
      chk("abort_result", ifc.result, 32'd0);
      chk("abort_norm", {norm_exp, norm_mantissa[23:0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_op(32'h40000000, 32'h40000000);
      finish_op(32'h40800000, 4, "two_plus_two", 0);
      start_op(32'h7F800000, 32'hFF800000);
`ifdef FP_ADD_SPECIALS_EN
      finish_op(32'h7FC00000, 2, "inf_minus_inf", 0);
      start_op(32'h7F800000, 32'h3F800000);
      finish_op(32'h7F800000, 2, "inf_plus_one", 0);
      start_op(32'h3F800000, 32'h7F800001);
      finish_op(32'h7FC00000, 2, "nan_in", 0);
`else
      finish_op(32'h00000000, 4, "inf_minus_inf", 0);
      chk("inf_minus_inf_known", 32'(!$isunknown(ifc.result)), 32'd1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
